// File: rtl/serial_subtractor64.sv
// Multi-cycle 64-bit subtractor: X - Y - BorrowIn evaluated Chunk bits per clock,
// with a start/busy/done handshake and registered result flags.
module serial_subtractor64 #(
  parameter int unsigned Chunk = 8
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        start_i,
  input  logic [63:0] x_i,
  input  logic [63:0] y_i,
  input  logic        borrow_in_i,
  output logic        busy_o,
  output logic        done_o,
  output logic [63:0] difference_o,
  output logic        borrow_out_o,
  output logic        overflow_o
);

  localparam int unsigned NumSlices = 64 / Chunk;
  localparam int unsigned CntW      = (NumSlices > 1) ? $clog2(NumSlices) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(NumSlices - 1);

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  state_e            state_q, state_d;
  logic [63:0]       x_q, x_d;
  logic [63:0]       y_q, y_d;
  logic              borrow_q, borrow_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [63:0]       res_q, res_d;
  logic              done_q, done_d;
  logic [63:0]       diff_q, diff_d;
  logic              bout_q, bout_d;
  logic              ovf_q, ovf_d;

  logic [5:0]        slice_base;
  logic [Chunk:0]    slice_diff;

  // Top bit of the (Chunk+1)-bit difference is the borrow out of this slice.
  assign slice_base = 6'(32'(cnt_q) * Chunk);
  assign slice_diff = {1'b0, x_q[slice_base +: Chunk]} - {1'b0, y_q[slice_base +: Chunk]}
                      - {{Chunk{1'b0}}, borrow_q};

  always_comb begin
    state_d  = state_q;
    x_d      = x_q;
    y_d      = y_q;
    borrow_d = borrow_q;
    cnt_d    = cnt_q;
    res_d    = res_q;
    done_d   = 1'b0;
    diff_d   = diff_q;
    bout_d   = bout_q;
    ovf_d    = ovf_q;

    case (state_q)
      StIdle: begin
        if (start_i) begin
          state_d  = StRun;
          x_d      = x_i;
          y_d      = y_i;
          borrow_d = borrow_in_i;
          cnt_d    = '0;
        end
      end
      StRun: begin
        res_d[slice_base +: Chunk] = slice_diff[Chunk-1:0];
        borrow_d = slice_diff[Chunk];
        cnt_d    = cnt_q + CntW'(1);
        if (cnt_q == LastCnt) begin
          state_d = StIdle;
          cnt_d   = '0;
          done_d  = 1'b1;
          diff_d  = res_d;
          bout_d  = slice_diff[Chunk];
          ovf_d   = (x_q[63] ^ y_q[63]) & (res_d[63] ^ x_q[63]);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q  <= StIdle;
      x_q      <= '0;
      y_q      <= '0;
      borrow_q <= 1'b0;
      cnt_q    <= '0;
      res_q    <= '0;
      done_q   <= 1'b0;
      diff_q   <= '0;
      bout_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      x_q      <= x_d;
      y_q      <= y_d;
      borrow_q <= borrow_d;
      cnt_q    <= cnt_d;
      res_q    <= res_d;
      done_q   <= done_d;
      diff_q   <= diff_d;
      bout_q   <= bout_d;
      ovf_q    <= ovf_d;
    end
  end

  assign busy_o       = (state_q == StRun);
  assign done_o       = done_q;
  assign difference_o = diff_q;
  assign borrow_out_o = bout_q;
  assign overflow_o   = ovf_q;

endmodule

// File: tb/tb_serial_subtractor64.sv
// Bench for serial_subtractor64 at Chunk = 8, 1 and 64 against a whole-word
// arithmetic reference model.
module tb_serial_subtractor64;

  logic        clk = 1'b0;
  logic        rst_n [3];
  logic        start [3];
  logic [63:0] xin   [3];
  logic [63:0] yin   [3];
  logic        bin   [3];
  logic        busy  [3];
  logic        done  [3];
  logic [63:0] diff  [3];
  logic        bout  [3];
  logic        ovf   [3];

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  serial_subtractor64 #(.Chunk(8)) u_dut8 (
    .clk_i(clk), .rst_ni(rst_n[0]), .start_i(start[0]), .x_i(xin[0]), .y_i(yin[0]),
    .borrow_in_i(bin[0]), .busy_o(busy[0]), .done_o(done[0]), .difference_o(diff[0]),
    .borrow_out_o(bout[0]), .overflow_o(ovf[0])
  );
  serial_subtractor64 #(.Chunk(1)) u_dut1 (
    .clk_i(clk), .rst_ni(rst_n[1]), .start_i(start[1]), .x_i(xin[1]), .y_i(yin[1]),
    .borrow_in_i(bin[1]), .busy_o(busy[1]), .done_o(done[1]), .difference_o(diff[1]),
    .borrow_out_o(bout[1]), .overflow_o(ovf[1])
  );
  serial_subtractor64 #(.Chunk(64)) u_dut64 (
    .clk_i(clk), .rst_ni(rst_n[2]), .start_i(start[2]), .x_i(xin[2]), .y_i(yin[2]),
    .borrow_in_i(bin[2]), .busy_o(busy[2]), .done_o(done[2]), .difference_o(diff[2]),
    .borrow_out_o(bout[2]), .overflow_o(ovf[2])
  );

  function automatic int lat_of(input int d);
    return (d == 0) ? 8 : (d == 1) ? 64 : 1;
  endfunction

  function automatic logic [63:0] rnd64();
    logic [63:0] v;
    case ($urandom_range(0, 5))
      0:       v = '0;
      1:       v = '1;
      2:       v = 64'h8000_0000_0000_0000;
      3:       v = 64'h7FFF_FFFF_FFFF_FFFF;
      default: v = {$urandom(), $urandom()};
    endcase
    return v;
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model(input logic [63:0] a, input logic [63:0] b, input logic bi,
                       output logic [63:0] d, output logic bo, output logic ov);
    d  = a - b - 64'(bi);
    bo = ({1'b0, a} < ({1'b0, b} + 65'(bi)));
    ov = (a[63] != b[63]) && (d[63] != a[63]);
  endtask

  task automatic check_result(input int d, input string tag, input logic [63:0] a,
                              input logic [63:0] b, input logic bi);
    logic [63:0] ed;
    logic        eb, eo;
    model(a, b, bi, ed, eb, eo);
    check($sformatf("c%0d %s diff", lat_of(d), tag), diff[d], ed);
    check($sformatf("c%0d %s borrow", lat_of(d), tag), 64'(bout[d]), 64'(eb));
    check($sformatf("c%0d %s ovf", lat_of(d), tag), 64'(ovf[d]), 64'(eo));
  endtask

  task automatic check_zero(input int d, input string tag);
    check($sformatf("c%0d %s busy", lat_of(d), tag), 64'(busy[d]), 64'd0);
    check($sformatf("c%0d %s done", lat_of(d), tag), 64'(done[d]), 64'd0);
    check($sformatf("c%0d %s diff", lat_of(d), tag), diff[d], 64'd0);
    check($sformatf("c%0d %s borrow", lat_of(d), tag), 64'(bout[d]), 64'd0);
    check($sformatf("c%0d %s ovf", lat_of(d), tag), 64'(ovf[d]), 64'd0);
  endtask

  // Present operands with Start for one edge, then scramble the inputs.
  task automatic launch(input int d, input logic [63:0] a, input logic [63:0] b,
                        input logic bi);
    xin[d] = a; yin[d] = b; bin[d] = bi; start[d] = 1'b1;
    step();
    start[d] = 1'b0;
    xin[d] = {$urandom(), $urandom()};
    yin[d] = {$urandom(), $urandom()};
    bin[d] = 1'($urandom());
  endtask

  // Edges until done is seen, with busy tracked on every intermediate cycle.
  task automatic wait_done(input int d, output int edges, output bit busy_ok);
    edges = 0;
    busy_ok = 1'b1;
    while (done[d] !== 1'b1 && edges < 80) begin
      if (busy[d] !== 1'b1) busy_ok = 1'b0;
      step();
      edges++;
    end
  endtask

  task automatic do_op(input int d, input string tag, input logic [63:0] a,
                       input logic [63:0] b, input logic bi);
    int edges;
    bit bok;
    launch(d, a, b, bi);
    check($sformatf("c%0d %s busy@accept", lat_of(d), tag), 64'(busy[d]), 64'd1);
    wait_done(d, edges, bok);
    check($sformatf("c%0d %s latency", lat_of(d), tag), 64'(edges), 64'(lat_of(d)));
    check($sformatf("c%0d %s busy during run", lat_of(d), tag), 64'(bok), 64'd1);
    check($sformatf("c%0d %s busy@done", lat_of(d), tag), 64'(busy[d]), 64'd0);
    check_result(d, tag, a, b, bi);
    step();
    check($sformatf("c%0d %s done pulse", lat_of(d), tag), 64'(done[d]), 64'd0);
    check_result(d, {tag, " hold"}, a, b, bi);
  endtask

  task automatic test_b2b(input int d);
    logic [63:0] a, b, c, e;
    int edges, pre;
    bit bok;
    a = rnd64(); b = rnd64();
    pre = 0;
    launch(d, a, b, 1'b1);
    if (lat_of(d) >= 4) begin
      step(); step();
      xin[d] = ~a; yin[d] = ~b; bin[d] = 1'b0; start[d] = 1'b1;
      step();
      start[d] = 1'b0;
      pre = 3;
    end
    wait_done(d, edges, bok);
    check($sformatf("c%0d ignore latency", lat_of(d)), 64'(edges + pre), 64'(lat_of(d)));
    check_result(d, "ignore", a, b, 1'b1);
    c = rnd64(); e = rnd64();
    xin[d] = c; yin[d] = e; bin[d] = 1'b0; start[d] = 1'b1;
    step();
    start[d] = 1'b0;
    check($sformatf("c%0d b2b busy", lat_of(d)), 64'(busy[d]), 64'd1);
    wait_done(d, edges, bok);
    check($sformatf("c%0d b2b latency", lat_of(d)), 64'(edges), 64'(lat_of(d)));
    check_result(d, "b2b", c, e, 1'b0);
    step();
  endtask

  task automatic test_reset(input int d);
    int k;
    bit seen;
    k = (lat_of(d) < 4) ? lat_of(d) : 4;
    launch(d, 64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b0);
    for (int i = 1; i < k; i++) step();
    rst_n[d] = 1'b0;
    step();
    check_zero(d, "midrun reset");
    rst_n[d] = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < lat_of(d) + 4; i++) begin
      step();
      if (done[d] === 1'b1) seen = 1'b1;
    end
    check($sformatf("c%0d no done after reset", lat_of(d)), 64'(seen), 64'd0);
    do_op(d, "post reset", 64'd10, 64'd4, 1'b0);
  endtask

  initial begin
    for (int d = 0; d < 3; d++) begin
      rst_n[d] = 1'b0; start[d] = 1'b0; xin[d] = '0; yin[d] = '0; bin[d] = 1'b0;
    end
    step(); step(); step();
    for (int d = 0; d < 3; d++) check_zero(d, "reset");
    for (int d = 0; d < 3; d++) rst_n[d] = 1'b1;
    step();

    for (int d = 0; d < 3; d++) begin
      do_op(d, "5-3", 64'd5, 64'd3, 1'b0);
      do_op(d, "0-1", 64'd0, 64'd1, 1'b0);
      do_op(d, "big-1-1", 64'd999999999, 64'd1, 1'b1);
      do_op(d, "min-1", 64'h8000_0000_0000_0000, 64'd1, 1'b0);
      test_b2b(d);
      test_reset(d);
      for (int i = 0; i < 15; i++) do_op(d, $sformatf("rnd%0d", i), rnd64(), rnd64(),
                                        1'($urandom()));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
